// File: rtl/vedic_pkg.sv
// Shared types and constants for the radix-4 sequential Vedic multiplier and its hex display.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_t   - multiplier control states
//   DIGITS    - number of seven-segment digits on the board
//   HEX_SEG   - active-low {dp,g,f,e,d,c,b,a} patterns for 0-F, dp off
//   hex_to_seg- nibble to segment lookup
package vedic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int DIGITS = 4;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,   // 0 1 2 3
    8'h99, 8'h92, 8'h82, 8'hF8,   // 4 5 6 7
    8'h80, 8'h90, 8'h88, 8'h83,   // 8 9 A b
    8'hC6, 8'hA1, 8'h86, 8'h8E    // C d E F
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/hex_seg_scan.sv
// Time-multiplexed 4-digit hex display driver for a 16-bit value.
// Latency: segments/anodes are registered, one cycle behind value and the refresh counter.
// Backpressure: none; free-running scan, value is sampled every cycle.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   value[15:0]     - nibble k is shown on digit k
//   segments[7:0]   - active-low {dp,g,f,e,d,c,b,a}, dp always off
//   anodes[3:0]     - active-low one-hot digit select
module hex_seg_scan
  import vedic_pkg::*;
#(
  parameter int REFRESH_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  output logic [7:0]  segments,
  output logic [3:0]  anodes
);

  logic [REFRESH_DIV-1:0] cnt_q, cnt_d;
  logic [7:0]             seg_q, seg_d;
  logic [3:0]             an_q,  an_d;
  logic [1:0]             digit;
  logic [3:0]             nib;

  always_comb begin
    cnt_d = cnt_q + REFRESH_DIV'(1);
    // Top two counter bits pick the digit, so each digit is lit for
    // 2^(REFRESH_DIV-2) cycles before moving on.
    digit = cnt_q[REFRESH_DIV-1 -: 2];
    nib   = value[{digit, 2'b00} +: 4];
    seg_d = hex_to_seg(nib);
    an_d  = ~(4'b0001 << digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      seg_q <= HEX_SEG[0];
      an_q  <= 4'b1110;
    end else begin
      cnt_q <= cnt_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign segments = seg_q;
  assign anodes   = an_q;

endmodule

// File: rtl/vedic_mult_seq.sv
// W x W unsigned radix-4 sequential multiplier built from 2-bit Vedic partial products.
// Latency: start accepted at cycle T, done pulses with the product at T+W/2+1.
// Backpressure: none; start is ignored while busy, accepted in IDLE (including the done cycle).
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   start, a, b       - operation request and operands, captured when accepted
//   busy              - high while iterating
//   done              - one-cycle pulse, product valid
//   product[2W-1:0]   - registered result, held until the next completion
//   segments, anodes  - hex display of product[15:0] when HEX_DISPLAY_EN is defined,
//                       otherwise tied off (all high)
module vedic_mult_seq
  import vedic_pkg::*;
#(
  parameter int W           = 8,
  parameter int REFRESH_DIV = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [7:0]     segments,
  output logic [3:0]     anodes
);

  localparam int PW    = 2 * W;
  localparam int STEPS = W / 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if ((W < 2) || ((W % 2) != 0) || (REFRESH_DIV < 2)) begin : g_bad_param
    $error("vedic_mult_seq: W must be even and >= 2, REFRESH_DIV >= 2");
  end

  state_t            state_q, state_d;
  logic [PW-1:0]     a_q, a_d;         // multiplicand, pre-shifted by 2i
  logic [W-1:0]      b_q, b_d;         // multiplier, shifted so bits [1:0] are the current digit
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;
  logic              done_q, done_d;
  logic [PW-1:0]     pp;

  // 2-bit Vedic cross product: vertical term a*b0 plus crosswise term a*b1
  // shifted one place. Since a_q already carries the 2i alignment, the sum
  // is the shifted partial product directly.
  always_comb begin
    pp = (b_q[0] ? a_q : '0) + (b_q[1] ? (a_q << 1) : '0);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = PW'(a);
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + pp;
        a_d   = a_q << 2;
        b_d   = b_q >> 2;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          // Final digit: publish the sum straight from this step's adder so
          // done lands one cycle after the last CALC cycle.
          product_d = acc_q + pp;
          done_d    = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = done_q;
  assign product = product_q;

`ifdef HEX_DISPLAY_EN
  logic [15:0] disp_value;

  // Only the low 16 product bits fit on four digits; narrow products are
  // zero-extended so the unused upper digits read 0.
  if (PW >= 16) begin : g_disp_wide
    assign disp_value = product_q[15:0];
  end else begin : g_disp_narrow
    assign disp_value = {{(16 - PW){1'b0}}, product_q};
  end

  hex_seg_scan #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_hex_seg_scan (
    .clk      (clk),
    .rst      (rst),
    .value    (disp_value),
    .segments (segments),
    .anodes   (anodes)
  );
`else
  assign segments = 8'hFF;
  assign anodes   = 4'hF;
`endif

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Self-checking bench for vedic_mult_seq (W=8, REFRESH_DIV=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_vedic_mult_seq;

  localparam int W  = 8;
  localparam int RD = 4;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [PW-1:0] product;
  logic [7:0]    segments;
  logic [3:0]    anodes;

  int checks = 0;
  int errors = 0;

  vedic_mult_seq #(.W(W), .REFRESH_DIV(RD)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .segments (segments),
    .anodes   (anodes)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An accepted start books a result a*b that appears W/2 edges later;
  // busy is simply "a result is still pending".
  int            m_left;
  logic [PW-1:0] m_pend;
  logic [PW-1:0] m_prod;
  logic          m_done;
  logic          m_valid = 1'b0;
  int            m_ticks;
  logic [7:0]    m_seg;
  logic [3:0]    m_an;

  function automatic logic [7:0] tb_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_left  <= 0;
      m_pend  <= '0;
      m_prod  <= '0;
      m_done  <= 1'b0;
      m_ticks <= 0;
      m_seg   <= 8'hC0;
      m_an    <= 4'b1110;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_prod <= m_pend;
          m_done <= 1'b1;
        end
      end else if (start) begin
        m_pend <= PW'(a) * PW'(b);
        m_left <= W / 2;
      end
      // Display shows the product as it stood before this edge.
      m_ticks <= (m_ticks + 1) % (1 << RD);
      m_seg   <= tb_seg(4'((m_prod[15:0]) >> (4 * ((m_ticks >> (RD - 2)) % 4))));
      m_an    <= ~(4'b0001 << ((m_ticks >> (RD - 2)) % 4));
    end
  end

  // ---------------- continuous compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      check("product", 32'(product), 32'(m_prod));
`ifdef HEX_DISPLAY_EN
      check("segments", 32'(segments), 32'(m_seg));
      check("anodes", 32'(anodes), 32'(m_an));
`else
      check("segments_off", 32'(segments), 32'h0000_00FF);
      check("anodes_off", 32'(anodes), 32'h0000_000F);
`endif
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues start in the current cycle, waits (bounded) for done, checks
  // latency and the literal product. Returns in the done cycle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [PW-1:0] exp, input string name);
    int lat;
    a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(W / 2 + 1));
    check({name, "_product"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    step(); step(); step();
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_product", 32'(product), 32'h0);
    rst = 1'b0;
    step();

    // Basic: 13 * 11 = 143, busy for 4 cycles, held after done.
    a = 8'd13; b = 8'd11; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) ndone++;
      step();
    end
    check("basic_busy_cycles", 32'(ndone), 32'd4);
    check("basic_done", 32'(done), 32'h1);
    check("basic_product", 32'(product), 32'h008F);
    step(); step(); step();
    check("basic_held", 32'(product), 32'h008F);
    check("basic_done_low", 32'(done), 32'h0);

    run_op(8'd255, 8'd255, 16'hFE01, "max");
    run_op(8'd0, 8'd200, 16'h0000, "zero");

    // Back-to-back: start again in a done cycle.
    run_op(8'd6, 8'd6, 16'd36, "b2b_first");
    run_op(8'd7, 8'd9, 16'd63, "b2b_second");
    step(); step();

    // Second start during CALC is ignored.
    a = 8'd20; b = 8'd30; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 8'd1; b = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      step();
    end
    check("ignored_done_count", 32'(ndone), 32'd1);
    check("ignored_product", 32'(product), 32'd600);

    // Reset mid-CALC aborts.
    a = 8'd100; b = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_product", 32'(product), 32'h0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      step();
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_op(8'd9, 8'd9, 16'd81, "after_abort");

`ifdef HEX_DISPLAY_EN
    run_op(8'd255, 8'd255, 16'hFE01, "disp_op");
    begin
      int n = 0;
      while (anodes != 4'b1110 && n < 40) begin
        step();
        n++;
      end
      check("disp_digit0_seg", 32'(segments), 32'h0000_00F9);
      n = 0;
      while (anodes != 4'b0111 && n < 40) begin
        step();
        n++;
      end
      check("disp_digit3_seg", 32'(segments), 32'h0000_008E);
    end
`endif

    // Randomized traffic: random starts (also while busy) and operands.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
      step();
    end
    start = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
